// File: rtl/alu_regfile_pkg.sv
// Shared types and constants for the bus-mapped ALU register block:
// opcodes, FSM states, register map and STATUS bit positions.
package alu_regfile_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    localparam int REG_OPA    = 0;
    localparam int REG_OPB    = 1;
    localparam int REG_CTRL   = 2;
    localparam int REG_STATUS = 3;
    localparam int REG_RES_LO = 4;
    localparam int REG_RES_HI = 5;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/alu_regfile_if.sv
// Register bus plus result/status outputs of the ALU register block.
interface alu_regfile_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_wr;
    logic                    enable;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [2*DATA_WIDTH-1:0] res_out;
    logic                    res_valid;
    logic                    busy;

    modport master (
        output addr, wr_data, rd_wr, enable,
        input  rd_data, res_out, res_valid, busy
    );

    modport slave (
        input  addr, wr_data, rd_wr, enable,
        output rd_data, res_out, res_valid, busy
    );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// DATA_WIDTH iterations; done/product are presented during the final iteration.
module shift_add_mul #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic                    run_r;
    logic [CW-1:0]           cnt_r;
    logic [2*DATA_WIDTH-1:0] acc_r;
    logic [2*DATA_WIDTH-1:0] mcand_r;
    logic [DATA_WIDTH-1:0]   mplier_r;
    logic [2*DATA_WIDTH-1:0] addend_s;
    logic [2*DATA_WIDTH-1:0] acc_next_s;

    // Partial-product accumulation for the current iteration.
    always_comb begin
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = '0;
        end
        acc_next_s = acc_r + addend_s;
    end

    // The core captures product on the same edge that retires the last iteration.
    assign done    = run_r && (cnt_r == CW'(DATA_WIDTH - 1));
    assign product = acc_next_s;

    // Operand load on start, then one shift-add step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r    <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else if (start) begin
            run_r    <= 1'b1;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= {{DATA_WIDTH{1'b0}}, a};
            mplier_r <= b;
        end else if (run_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
            if (done) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_regfile_core.sv
// Bus-mapped ALU: operand/control register file, start/busy/done FSM,
// single-cycle datapath and an iterative multiplier for MUL.
module alu_regfile_core
    import alu_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic         clk,
    input  logic         reset,
    alu_regfile_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] SHIFT_MOD = DATA_WIDTH'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   opa_r, opb_r, a_snap_r, b_snap_r, rd_data_r;
    alu_op_e                 op_r, op_snap_r;
    state_e                  state_r;
    logic                    busy_r, done_r, err_r, res_valid_r;
    logic [2*DATA_WIDTH-1:0] res_r;

    logic                    wr_s, rd_s, start_req_s, status_rd_s;
    logic                    finish_s, can_start_s, mul_start_s, mul_done_s;
    alu_op_e                 new_op_s;
    logic [2*DATA_WIDTH-1:0] mul_product_s, alu_res_s, fin_res_s;
    logic [DATA_WIDTH-1:0]   status_s, rd_next_s;

    function automatic logic [2*DATA_WIDTH-1:0] alu_eval(
        input alu_op_e               op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] wa, wb;
        logic [DATA_WIDTH-1:0]   sh;
        logic [DATA_WIDTH:0]     diff;
        wa   = {{DATA_WIDTH{1'b0}}, a};
        wb   = {{DATA_WIDTH{1'b0}}, b};
        sh   = b % SHIFT_MOD;
        diff = {1'b0, a} - {1'b0, b};
        case (op)
            OP_ADD:  alu_eval = wa + wb;
            OP_SUB:  alu_eval = {{(DATA_WIDTH-1){1'b0}}, diff};
            OP_AND:  alu_eval = wa & wb;
            OP_OR:   alu_eval = wa | wb;
            OP_XOR:  alu_eval = wa ^ wb;
            OP_SHL:  alu_eval = wa << sh;
            OP_SHR:  alu_eval = wa >> sh;
            default: alu_eval = '0;
        endcase
    endfunction

    // A new START is taken whenever the FSM is idle or retiring on this same edge.
    assign wr_s        = bus.enable && !bus.rd_wr;
    assign rd_s        = bus.enable && bus.rd_wr;
    assign start_req_s = wr_s && (bus.addr == ADDR_WIDTH'(REG_CTRL)) && bus.wr_data[DATA_WIDTH-1];
    assign status_rd_s = rd_s && (bus.addr == ADDR_WIDTH'(REG_STATUS));
    assign new_op_s    = alu_op_e'(bus.wr_data[2:0]);
    assign finish_s    = (state_r == ST_EXEC) || ((state_r == ST_MUL) && mul_done_s);
    assign can_start_s = (state_r == ST_IDLE) || finish_s;
    assign mul_start_s = start_req_s && can_start_s && (new_op_s == OP_MUL);
    assign alu_res_s   = alu_eval(op_snap_r, a_snap_r, b_snap_r);
    assign fin_res_s   = (state_r == ST_MUL) ? mul_product_s : alu_res_s;

    shift_add_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (opa_r),
        .b       (opb_r),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Read-data mux over the register map; reserved addresses read zero.
    always_comb begin
        status_s            = '0;
        status_s[STAT_BUSY] = busy_r;
        status_s[STAT_DONE] = done_r;
        status_s[STAT_ERR]  = err_r;
        case (bus.addr)
            ADDR_WIDTH'(REG_OPA):    rd_next_s = opa_r;
            ADDR_WIDTH'(REG_OPB):    rd_next_s = opb_r;
            ADDR_WIDTH'(REG_CTRL):   rd_next_s = {{(DATA_WIDTH-3){1'b0}}, op_r};
            ADDR_WIDTH'(REG_STATUS): rd_next_s = status_s;
            ADDR_WIDTH'(REG_RES_LO): rd_next_s = res_r[DATA_WIDTH-1:0];
            ADDR_WIDTH'(REG_RES_HI): rd_next_s = res_r[2*DATA_WIDTH-1:DATA_WIDTH];
            default:                 rd_next_s = '0;
        endcase
    end

    // Operand and opcode registers; writes land even while an operation runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_r <= '0;
            opb_r <= '0;
            op_r  <= OP_ADD;
        end else if (wr_s) begin
            case (bus.addr)
                ADDR_WIDTH'(REG_OPA):  opa_r <= bus.wr_data;
                ADDR_WIDTH'(REG_OPB):  opb_r <= bus.wr_data;
                ADDR_WIDTH'(REG_CTRL): op_r  <= new_op_s;
                default: ;
            endcase
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r <= '0;
        end else if (rd_s) begin
            rd_data_r <= rd_next_s;
        end
    end

    // Control FSM, sticky flags and result capture; later assignments take priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            res_valid_r <= 1'b0;
            res_r       <= '0;
            a_snap_r    <= '0;
            b_snap_r    <= '0;
            op_snap_r   <= OP_ADD;
        end else begin
            res_valid_r <= 1'b0;
            if (status_rd_s) begin
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end
            if (finish_s) begin
                res_r       <= fin_res_s;
                res_valid_r <= 1'b1;
                done_r      <= 1'b1;
                busy_r      <= 1'b0;
                state_r     <= ST_IDLE;
            end else if ((state_r != ST_IDLE) && (state_r != ST_MUL)) begin
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
            end
            if (start_req_s) begin
                if (can_start_s) begin
                    a_snap_r  <= opa_r;
                    b_snap_r  <= opb_r;
                    op_snap_r <= new_op_s;
                    busy_r    <= 1'b1;
                    done_r    <= 1'b0;
                    state_r   <= (new_op_s == OP_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_data   = rd_data_r;
    assign bus.res_out   = res_r;
    assign bus.res_valid = res_valid_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_alu_regfile_core.sv
// Self-checking bench for alu_regfile_core (DATA_WIDTH=8, ADDR_WIDTH=3).
module tb_alu_regfile_core;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rv_count = 0;

    alu_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus();

    alu_regfile_core #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.res_valid === 1'b1) rv_count++;

    function automatic logic [15:0] ref_result(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = (a - b) & 32'h1FF;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * b;
            6: r = a * (2 ** (b % 8));
            default: r = a / (2 ** (b % 8));
        endcase
        return r[15:0];
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.enable = 1'b1; bus.rd_wr = 1'b0; bus.addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.enable = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus.enable = 1'b1; bus.rd_wr = 1'b1; bus.addr = a;
        @(posedge clk); #1;
        d = bus.rd_data;
        bus.enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; bus.enable = 1'b0; bus.rd_wr = 1'b0; bus.addr = 3'd0; bus.wr_data = 8'h00;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        n_checks++; if (bus.res_out !== 16'h0000) begin n_fail++; $display("FAIL reset_res_out: got %h expected 0000", bus.res_out); end
        n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", d); end
    endtask

    task automatic test_add();
        logic [7:0] d;
        bus_write(3'd0, 8'hFF); bus_write(3'd1, 8'h01); bus_write(3'd2, 8'h80);
        n_checks++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_start: got busy=%b valid=%b expected busy=1 valid=0", bus.busy, bus.res_valid); end
        idle(1);
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", bus.res_valid); end
        n_checks++; if (bus.res_out !== 16'h0100) begin n_fail++; $display("FAIL add_res: got %h expected 0100", bus.res_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_end: got %b expected 0", bus.busy); end
        idle(1);
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_pulse: got %b expected 0", bus.res_valid); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL add_status: got %h expected 02", d); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL add_status_clr: got %h expected 00", d); end
    endtask

    task automatic test_sub();
        logic [7:0] d;
        bus_write(3'd0, 8'h03); bus_write(3'd1, 8'h05); bus_write(3'd2, 8'h81);
        idle(1);
        n_checks++; if (bus.res_out !== 16'h01FE) begin n_fail++; $display("FAIL sub_res: got %h expected 01fe", bus.res_out); end
        bus_read(3'd4, d);
        n_checks++; if (d !== 8'hFE) begin n_fail++; $display("FAIL sub_res_lo: got %h expected fe", d); end
        bus_read(3'd5, d);
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL sub_res_hi: got %h expected 01", d); end
        bus_write(3'd0, 8'h03);
        n_checks++; if (bus.rd_data !== 8'h01) begin n_fail++; $display("FAIL rd_data_hold: got %h expected 01", bus.rd_data); end
    endtask

    task automatic test_mul();
        int rv0;
        bus_write(3'd0, 8'hFF); bus_write(3'd1, 8'hFF);
        rv0 = rv_count;
        bus_write(3'd2, 8'h85);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_start: got %b expected 1", bus.busy); end
        for (int i = 1; i < 8; i++) begin
            idle(1);
            n_checks++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mul_busy_cycle%0d: got busy=%b valid=%b expected busy=1 valid=0", i, bus.busy, bus.res_valid); end
        end
        idle(1);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_done_edge: got valid=%b busy=%b expected valid=1 busy=0", bus.res_valid, bus.busy); end
        n_checks++; if (bus.res_out !== 16'hFE01) begin n_fail++; $display("FAIL mul_res: got %h expected fe01", bus.res_out); end
        idle(3);
        n_checks++; if (rv_count - rv0 !== 1) begin n_fail++; $display("FAIL mul_pulses: got %0d expected 1", rv_count - rv0); end
    endtask

    task automatic test_start_during_mul();
        logic [7:0] d;
        bit found;
        bus_write(3'd2, 8'h85);
        bus_write(3'd2, 8'h80);
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h05) begin n_fail++; $display("FAIL busy_start_status: got %h expected 05", d); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL busy_start_status2: got %h expected 01", d); end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin idle(1); if (bus.res_valid === 1'b1) found = 1'b1; end
        n_checks++; if (!found || bus.res_out !== 16'hFE01) begin n_fail++; $display("FAIL busy_start_res: got found=%b res=%h expected found=1 res=fe01", found, bus.res_out); end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] d;
        int rv0;
        bus_read(3'd0, d);
        bus_write(3'd2, 8'h85);
        idle(3);
        rv0 = rv_count;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.res_out !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_res: got %h expected 0000", bus.res_out); end
        n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rd_data: got %h expected 00", bus.rd_data); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        idle(10);
        n_checks++; if (rv_count !== rv0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", rv_count - rv0); end
        bus_read(3'd0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_mid_opa: got %h expected 00", d); end
    endtask

    task automatic test_shl_reserved();
        logic [7:0] d;
        bus_write(3'd0, 8'h81); bus_write(3'd1, 8'h0B); bus_write(3'd2, 8'h86);
        idle(1);
        n_checks++; if (bus.res_out !== 16'h0408) begin n_fail++; $display("FAIL shl_res: got %h expected 0408", bus.res_out); end
        bus_read(3'd4, d);
        bus_read(3'd7, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reserved_rd7: got %h expected 00", d); end
        bus_write(3'd6, 8'h5A);
        bus_read(3'd6, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reserved_wr6: got %h expected 00", d); end
        bus_read(3'd0, d);
        n_checks++; if (d !== 8'h81) begin n_fail++; $display("FAIL reserved_opa_kept: got %h expected 81", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bus_write(3'd0, 8'h40); bus_write(3'd1, 8'h30);
        bus_write(3'd2, 8'h80);
        bus_write(3'd2, 8'h81);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_out !== 16'h0070 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got valid=%b res=%h busy=%b expected 1/0070/1", bus.res_valid, bus.res_out, bus.busy); end
        idle(1);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_out !== 16'h0010 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got valid=%b res=%h busy=%b expected 1/0010/0", bus.res_valid, bus.res_out, bus.busy); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL b2b_status: got %h expected 02", d); end
        bus_write(3'd2, 8'h85);
        idle(7);
        bus_write(3'd2, 8'h84);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_out !== 16'h0C00 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_mul: got valid=%b res=%h busy=%b expected 1/0c00/1", bus.res_valid, bus.res_out, bus.busy); end
        idle(1);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_out !== 16'h0070 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_after_mul: got valid=%b res=%h busy=%b expected 1/0070/0", bus.res_valid, bus.res_out, bus.busy); end
        bus_read(3'd3, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL b2b_mul_status: got %h expected 02", d); end
    endtask

    task automatic test_random();
        logic [7:0] d, a, b;
        logic [2:0] op;
        logic [15:0] exp;
        bit found;
        for (int it = 0; it < 40; it++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            op = 3'($urandom_range(0, 7));
            exp = ref_result(int'(op), int'(a), int'(b));
            bus_write(3'd0, a); bus_write(3'd1, b); bus_write(3'd2, {5'b10000, op});
            if (op == 3'd5) bus_write(3'd0, 8'($urandom_range(0, 255)));
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                if (bus.res_valid === 1'b1) found = 1'b1; else idle(1);
            end
            n_checks++; if (!found || bus.res_out !== exp) begin n_fail++; $display("FAIL rand_res it%0d op%0d a=%h b=%h: got found=%b res=%h expected %h", it, op, a, b, found, bus.res_out, exp); end
            bus_read(3'd4, d);
            n_checks++; if (d !== exp[7:0]) begin n_fail++; $display("FAIL rand_lo it%0d: got %h expected %h", it, d, exp[7:0]); end
            bus_read(3'd5, d);
            n_checks++; if (d !== exp[15:8]) begin n_fail++; $display("FAIL rand_hi it%0d: got %h expected %h", it, d, exp[15:8]); end
            bus_read(3'd3, d);
            n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL rand_status it%0d: got %h expected 02", it, d); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_start_during_mul();
        test_reset_mid_mul();
        test_shl_reserved();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
